rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive blocked cycles of port B before port A is forcibly stalled; legal range 1..15.
REQ-002 SHALL have port clk  in  1  single clock, rising-edge active.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port a_valid  in  1  pipeline write-back request; port A has no ready signal.
REQ-005 SHALL have ports a_dest  in  3, a_data  in  16, a_ben  in  2: destination, data, byte enables for A (bit1 = high byte, bit0 = low byte).
REQ-006 SHALL have port a_stall  out  1  holds the write-back stage; A requests are ignored while it is high.
REQ-007 SHALL have port b_valid  in  1  long-latency unit write request.
REQ-008 SHALL have ports b_dest  in  3, b_data  in  16, b_ben  in  2: destination, data, byte enables for B.
REQ-009 SHALL have port b_ready  out  1  combinational accept for B; transfer occurs when b_valid && b_ready.
REQ-010 SHALL have ports w_en  out  2, d  out  3, wr  out  16: registered write port to the register file, same encoding as the byte enables.
REQ-011 SHALL have port pend  out  8  one bit per GPR; set while a B request targeting that GPR waits unaccepted.

Function
REQ-012 SHALL select a winner each cycle and register it onto w_en/d/wr at the next rising edge (1-cycle latency); w_en=00 when there is no winner.
REQ-013 SHALL treat a request with ben=00 as consumed with no write (w_en=00); B still handshakes.
REQ-014 SHALL use FSM states NORMAL and FORCE_B.
REQ-015 In NORMAL: A valid wins over B; b_ready=0 whenever A wins, except under REQ-016.
REQ-016 SHALL coalesce when both ports are valid, a_dest==b_dest, and (a_ben & b_ben)==00: one write with w_en=a_ben|b_ben, the high byte taken from whichever port enables it and the low byte likewise, with b_ready=1.
REQ-017 SHALL keep a 4-bit wait counter: increment when b_valid && !b_ready, clear on a B transfer or when b_valid=0, and saturate at 15.
REQ-018 SHALL go NORMAL->FORCE_B at the edge where the counter reaches STARVE_LIMIT.
REQ-019 In FORCE_B: a_stall=1 (registered), b_ready=1, A inputs ignored; exit to NORMAL after exactly one cycle, even if b_valid=0 (cycle wasted, w_en=00).
REQ-020 In NORMAL, a_stall=0.
REQ-021 SHALL have pend combinational: pend[b_dest]=b_valid && !b_ready; all other bits 0.
REQ-022 With only B valid in NORMAL, SHALL set b_ready=1 in the same cycle.

Reset
REQ-023 SHALL on rst_n low immediately force w_en=00, d=0, wr=0, a_stall=0, state=NORMAL, and wait counter=0; b_ready and pend follow the combinational rules from the reset state.
REQ-024 SHALL on reset mid-FORCE_B drop the forced cycle; no pending write survives reset.
REQ-025 SHALL release reset synchronously to clk, with the first arbitration on the first rising edge that sees rst_n high.

Structure
REQ-026 SHALL place in a shared package (mips_pkg): the state enum {NORMAL, FORCE_B}, the BEN_* byte-enable constants (00/01/10/11), and the 16-bit data and 3-bit register-index typedefs.
REQ-027 SHALL implement the starvation counter plus FSM as sub-module rf_starve_ctrl (inputs b_valid, b_fire; outputs force_b, a_stall); the merge/mux logic stays in the top level.

Verification
REQ-028 A only: a_valid=1, a_dest=3, a_data=16'hBEEF, a_ben=11 -> next edge w_en=11, d=3, wr=BEEF; b_ready don't-care.
REQ-029 Coalesce: A dest=5 ben=01 data=00AA with B dest=5 ben=10 data=CC00 -> b_ready=1 same cycle; next edge w_en=11, d=5, wr=CCAA.
REQ-030 Starvation (limit 4): a_valid held 1, B dest=2 held valid -> pend[2]=1 for 4 cycles, then a_stall=1 and b_ready=1 for one cycle, w_en carries the B write next edge, pend=0.
REQ-031 Conflict without merge: same dest 6, both ben=11 -> A written, b_ready=0, pend[6]=1; B granted in the first cycle a_valid=0.
REQ-032 Reset mid-force: assert rst_n=0 while a_stall=1 -> a_stall=0 and w_en=00 immediately; after release, B alone is granted on the first edge.
REQ-033 Null write: B valid with ben=00 -> b_ready=1, next-edge w_en=00, counter cleared.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared arbiter state, byte-enable codes and register-file datatypes.
package mips_pkg;
    typedef enum logic {NORMAL, FORCE_B} state_t;
    localparam logic [1:0] BEN_NONE = 2'b00;
    localparam logic [1:0] BEN_LO   = 2'b01;
    localparam logic [1:0] BEN_HI   = 2'b10;
    localparam logic [1:0] BEN_ALL  = 2'b11;
    typedef logic [15:0] data_t;
    typedef logic [2:0]  reg_idx_t;
endpackage

// File: rtl/rf_starve_ctrl.sv
// rf_starve_ctrl: counts cycles port B is blocked and forces a one-cycle B grant at the limit.
module rf_starve_ctrl
    import mips_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic b_valid,
    input  logic b_fire,
    output logic force_b,
    output logic a_stall
);
    state_t     r_state, w_state_next;
    logic [3:0] r_cnt, w_cnt_next;
    always_comb begin
        w_cnt_next   = (!b_valid || b_fire) ? 4'd0 : ((r_cnt == 4'd15) ? r_cnt : r_cnt + 4'd1);
        w_state_next = (r_state == NORMAL && w_cnt_next == 4'(STARVE_LIMIT)) ? FORCE_B : NORMAL;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= NORMAL;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end
    // The state flop itself is the stall, so a_stall is glitch-free.
    assign force_b = (r_state == FORCE_B);
    assign a_stall = force_b;
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: arbitrates pipeline write-back (A) and long-latency unit (B) onto one
// registered register-file write port, merging disjoint byte writes to the same GPR.
module rf_write_arbiter
    import mips_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    input  logic [2:0]  a_dest,
    input  logic [15:0] a_data,
    input  logic [1:0]  a_ben,
    output logic        a_stall,
    input  logic        b_valid,
    input  logic [2:0]  b_dest,
    input  logic [15:0] b_data,
    input  logic [1:0]  b_ben,
    output logic        b_ready,
    output logic [1:0]  w_en,
    output logic [2:0]  d,
    output logic [15:0] wr,
    output logic [7:0]  pend
);
    logic     w_force_b, w_a_act, w_merge, w_b_fire;
    logic [1:0] w_sel_en, r_w_en;
    reg_idx_t w_sel_d, r_d;
    data_t    w_sel_wr, r_wr;
    rf_starve_ctrl #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .b_valid (b_valid),
        .b_fire  (w_b_fire),
        .force_b (w_force_b),
        .a_stall (a_stall)
    );
    always_comb begin
        w_a_act  = a_valid && !w_force_b;
        w_merge  = w_a_act && b_valid && a_dest == b_dest && (a_ben & b_ben) == BEN_NONE;
        b_ready  = w_force_b || !w_a_act || w_merge;
        w_b_fire = b_valid && b_ready;
        w_sel_en = w_a_act ? (a_ben | (w_merge ? b_ben : BEN_NONE)) : (w_b_fire ? b_ben : BEN_NONE);
        w_sel_d  = w_a_act ? a_dest : (w_b_fire ? b_dest : '0);
        // Each byte comes from A unless only B enables it in a merged write.
        w_sel_wr = w_a_act ? {(w_merge && (a_ben & BEN_HI) == BEN_NONE) ? b_data[15:8] : a_data[15:8],
                              (w_merge && (a_ben & BEN_LO) == BEN_NONE) ? b_data[7:0]  : a_data[7:0]}
                           : (w_b_fire ? b_data : '0);
        pend     = (b_valid && !b_ready) ? (8'd1 << b_dest) : 8'd0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_en <= BEN_NONE;
            r_d    <= '0;
            r_wr   <= '0;
        end else begin
            r_w_en <= w_sel_en;
            r_d    <= w_sel_d;
            r_wr   <= w_sel_wr;
        end
    end
    assign w_en = r_w_en;
    assign d    = r_d;
    assign wr   = r_wr;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: vector table, corner-case sequences and a randomized reference model.
module tb_rf_write_arbiter;
    localparam int LIMIT = 4;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        a_valid, b_valid, a_stall, b_ready;
    logic [2:0]  a_dest, b_dest, d;
    logic [15:0] a_data, b_data, wr;
    logic [1:0]  a_ben, b_ben, w_en;
    logic [7:0]  pend;
    int checks = 0, failures = 0;
    bit m_force;
    int m_wait;

    always #5 clk = ~clk;

    rf_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data), .a_ben(a_ben), .a_stall(a_stall),
        .b_valid(b_valid), .b_dest(b_dest), .b_data(b_data), .b_ben(b_ben), .b_ready(b_ready),
        .w_en(w_en), .d(d), .wr(wr), .pend(pend)
    );

    typedef struct {
        logic av; logic [2:0] ad; logic [15:0] adt; logic [1:0] ab;
        logic bv; logic [2:0] bd; logic [15:0] bdt; logic [1:0] bb;
        logic rdy; logic [7:0] pnd; logic [1:0] wen; logic [2:0] wd; logic [15:0] wwr;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] bmask(input logic [1:0] en);
        return {{8{en[1]}}, {8{en[0]}}};
    endfunction

    task automatic check_write(input string tag, input logic [1:0] en, input logic [2:0] dd, input logic [15:0] ww);
        check({tag, ".w_en"}, 32'(w_en), 32'(en));
        if (en != 2'b00) begin
            check({tag, ".d"}, 32'(d), 32'(dd));
            check({tag, ".wr"}, 32'(wr & bmask(en)), 32'(ww & bmask(en)));
        end
    endtask

    task automatic drive(input logic av, input logic [2:0] ad, input logic [15:0] adt, input logic [1:0] ab,
                         input logic bv, input logic [2:0] bd, input logic [15:0] bdt, input logic [1:0] bb);
        a_valid = av; a_dest = ad; a_data = adt; a_ben = ab;
        b_valid = bv; b_dest = bd; b_data = bdt; b_ben = bb;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        vecs[0] = '{1, 3, 16'hBEEF, 2'b11, 0, 0, 16'h0000, 2'b00, 0, 8'h00, 2'b11, 3, 16'hBEEF};
        vecs[1] = '{1, 5, 16'h00AA, 2'b01, 1, 5, 16'hCC00, 2'b10, 1, 8'h00, 2'b11, 5, 16'hCCAA};
        vecs[2] = '{1, 6, 16'h1111, 2'b11, 1, 6, 16'h2222, 2'b11, 0, 8'h40, 2'b11, 6, 16'h1111};
        vecs[3] = '{0, 0, 16'h0000, 2'b00, 1, 7, 16'hABCD, 2'b10, 1, 8'h00, 2'b10, 7, 16'hABCD};
        vecs[4] = '{0, 0, 16'h0000, 2'b00, 1, 1, 16'hFFFF, 2'b00, 1, 8'h00, 2'b00, 0, 16'h0000};
        vecs[5] = '{1, 2, 16'h0011, 2'b01, 1, 3, 16'h2200, 2'b10, 0, 8'h08, 2'b01, 2, 16'h0011};
        vecs[6] = '{1, 4, 16'h0055, 2'b01, 1, 4, 16'h0066, 2'b01, 0, 8'h10, 2'b01, 4, 16'h0055};
        vecs[7] = '{1, 0, 16'h9999, 2'b00, 0, 0, 16'h0000, 2'b00, 0, 8'h00, 2'b00, 0, 16'h0000};
        vecs[8] = '{1, 1, 16'h12EE, 2'b10, 1, 1, 16'hEE34, 2'b01, 1, 8'h00, 2'b11, 1, 16'h1234};
        vecs[9] = '{0, 0, 16'h0000, 2'b00, 0, 0, 16'h0000, 2'b00, 1, 8'h00, 2'b00, 0, 16'h0000};

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        check("rst.w_en", 32'(w_en), 0);
        check("rst.d", 32'(d), 0);
        check("rst.wr", 32'(wr), 0);
        check("rst.a_stall", 32'(a_stall), 0);
        check("rst.b_ready", 32'(b_ready), 1);
        check("rst.pend", 32'(pend), 0);
        #9 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].av, vecs[i].ad, vecs[i].adt, vecs[i].ab, vecs[i].bv, vecs[i].bd, vecs[i].bdt, vecs[i].bb);
            @(negedge clk);
            check($sformatf("vec%0d.b_ready", i), 32'(b_ready), 32'(vecs[i].rdy));
            check($sformatf("vec%0d.pend", i), 32'(pend), 32'(vecs[i].pnd));
            check($sformatf("vec%0d.a_stall", i), 32'(a_stall), 0);
            tick();
            check_write($sformatf("vec%0d", i), vecs[i].wen, vecs[i].wd, vecs[i].wwr);
            idle(1);
        end

        // Conflict: B waits, then is granted the first cycle A goes away.
        drive(1, 6, 16'h1111, 2'b11, 1, 6, 16'h2222, 2'b11);
        @(negedge clk);
        check("conf.b_ready", 32'(b_ready), 0);
        check("conf.pend", 32'(pend), 32'h40);
        tick();
        check_write("conf.a", 2'b11, 6, 16'h1111);
        drive(0, 0, 0, 0, 1, 6, 16'h2222, 2'b11);
        @(negedge clk);
        check("conf.b_ready2", 32'(b_ready), 1);
        check("conf.pend2", 32'(pend), 0);
        tick();
        check_write("conf.b", 2'b11, 6, 16'h2222);
        idle(2);

        // Null write clears the wait counter.
        drive(1, 0, 16'h0, 2'b11, 1, 3, 16'h3333, 2'b11);
        for (int k = 0; k < 3; k++) tick();
        drive(0, 0, 0, 0, 1, 3, 16'h3333, 2'b00);
        @(negedge clk);
        check("null.b_ready", 32'(b_ready), 1);
        tick();
        check("null.w_en", 32'(w_en), 0);
        drive(1, 0, 16'h0, 2'b11, 1, 3, 16'h3333, 2'b11);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("null.stall%0d", k), 32'(a_stall), 0);
            tick();
        end
        idle(2);

        // Starvation of B under continuous A traffic.
        drive(1, 1, 16'h1234, 2'b11, 1, 2, 16'h0077, 2'b01);
        for (int k = 0; k < LIMIT; k++) begin
            @(negedge clk);
            check($sformatf("starve%0d.pend", k), 32'(pend), 32'h04);
            check($sformatf("starve%0d.a_stall", k), 32'(a_stall), 0);
            check($sformatf("starve%0d.b_ready", k), 32'(b_ready), 0);
            tick();
            check_write($sformatf("starve%0d", k), 2'b11, 1, 16'h1234);
        end
        @(negedge clk);
        check("force.a_stall", 32'(a_stall), 1);
        check("force.b_ready", 32'(b_ready), 1);
        check("force.pend", 32'(pend), 0);
        tick();
        check_write("force.b", 2'b01, 2, 16'h0077);
        drive(1, 1, 16'h1234, 2'b11, 0, 0, 0, 0);
        @(negedge clk);
        check("force.exit", 32'(a_stall), 0);
        tick();
        check_write("force.after", 2'b11, 1, 16'h1234);
        idle(2);

        // Reset while the forced cycle is active.
        begin
            bit found;
            found = 0;
            drive(1, 0, 16'h4444, 2'b11, 1, 2, 16'h5555, 2'b11);
            for (int k = 0; k < 10 && !found; k++) begin
                @(negedge clk);
                if (a_stall) found = 1;
                else tick();
            end
            check("rstf.reached", 32'(found), 1);
            if (found) begin
                rst_n = 1'b0;
                #1;
                check("rstf.a_stall", 32'(a_stall), 0);
                check("rstf.w_en", 32'(w_en), 0);
                check("rstf.d", 32'(d), 0);
                check("rstf.wr", 32'(wr), 0);
                drive(0, 0, 0, 0, 1, 2, 16'h5555, 2'b11);
                #1;
                check("rstf.b_ready", 32'(b_ready), 1);
                tick();
                check("rstf.hold", 32'(w_en), 0);
                @(negedge clk);
                rst_n = 1'b1;
                tick();
                check_write("rstf.first", 2'b11, 2, 16'h5555);
            end
        end
        idle(2);

        m_force = 0;
        m_wait = 0;
        for (int i = 0; i < 1500; i++) begin
            logic av, bv, merge, rdy;
            logic [2:0] ad, bd, ed;
            logic [15:0] adt, bdt, ew;
            logic [1:0] ab, bb, een;
            logic [7:0] ep;
            av = $urandom_range(0, 9) < 7;
            bv = $urandom_range(0, 9) < 6;
            ad = 3'($urandom_range(0, 3));
            bd = 3'($urandom_range(0, 3));
            ab = 2'($urandom_range(0, 3));
            bb = 2'($urandom_range(0, 3));
            adt = 16'($urandom);
            bdt = 16'($urandom);
            drive(av, ad, adt, ab, bv, bd, bdt, bb);
            merge = !m_force && av && bv && ad == bd && (ab & bb) == 2'b00;
            rdy = m_force || !av || merge;
            een = 2'b00; ed = 0; ew = 0;
            if (m_force || !av) begin
                if (bv) begin een = bb; ed = bd; ew = bdt; end
            end else begin
                een = ab | (merge ? bb : 2'b00);
                ed = ad;
                ew[15:8] = ab[1] ? adt[15:8] : bdt[15:8];
                ew[7:0]  = ab[0] ? adt[7:0] : bdt[7:0];
            end
            ep = (bv && !rdy) ? (8'd1 << bd) : 8'd0;
            @(negedge clk);
            check($sformatf("rnd%0d.a_stall", i), 32'(a_stall), 32'(m_force));
            check($sformatf("rnd%0d.b_ready", i), 32'(b_ready), 32'(rdy));
            check($sformatf("rnd%0d.pend", i), 32'(pend), 32'(ep));
            tick();
            check_write($sformatf("rnd%0d", i), een, ed, ew);
            m_wait = (bv && !rdy) ? ((m_wait < 15) ? m_wait + 1 : 15) : 0;
            m_force = !m_force && (m_wait == LIMIT);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
